// File: rtl/weight_fetch_pkg.sv
// Constants and FSM encoding shared by the controller, the weight-fetch stage and the array.
package weight_fetch_pkg;

    localparam int SYS_H_DEF = 8;
    localparam int SYS_W_DEF = 8;
    localparam int DW_DEF    = 8;
    localparam int AW_DEF    = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } wf_state_e;

endpackage

// File: rtl/weight_fetch.sv
// Streams SYS_H weight rows from the weight buffer into the array weight-load port.
// Request to w_done is SYS_H+2 cycles; no backpressure, abort by clr or w_read falling.
module weight_fetch
    import weight_fetch_pkg::*;
#(
    parameter int SYS_H = SYS_H_DEF,
    parameter int SYS_W = SYS_W_DEF,
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    localparam int RW   = (SYS_H > 1) ? $clog2(SYS_H) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_read,
    input  logic                  clr,
    input  logic [AW-1:0]         base_addr,
    output logic                  mem_en,
    output logic [AW-1:0]         mem_addr,
    input  logic [SYS_W*DW-1:0]   mem_rdata,
    output logic [SYS_W*DW-1:0]   w_data,
    output logic                  w_valid,
    output logic [RW-1:0]         w_row,
    output logic                  w_done
);

    localparam logic [RW-1:0] LAST_ROW = RW'(SYS_H - 1);

    wf_state_e       state_q, state_d;
    logic [RW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   base_q, base_d;
    logic            mem_en_d;
    logic [AW-1:0]   mem_addr_d;
    logic            w_valid_d;
    logic [RW-1:0]   w_row_d;
    logic            w_done_d;
    logic            abort;

    assign w_data = mem_rdata;
    assign abort  = clr || !w_read;

    // cnt_q is the row being issued in the current cycle while in ISSUE.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        base_d     = base_q;
        mem_en_d   = 1'b0;
        mem_addr_d = mem_addr;
        w_valid_d  = mem_en;
        w_row_d    = mem_en ? cnt_q : w_row;
        w_done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_read && !clr) begin
                    state_d    = ST_ISSUE;
                    base_d     = base_addr;
                    cnt_d      = '0;
                    mem_en_d   = 1'b1;
                    mem_addr_d = base_addr;
                end
            end
            ST_ISSUE: begin
                if (abort) begin
                    // Drop the read issued this cycle so it never shows as w_valid.
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    w_valid_d = 1'b0;
                end else if (cnt_q == LAST_ROW) begin
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d      = cnt_q + RW'(1);
                    mem_en_d   = 1'b1;
                    mem_addr_d = base_q + AW'(cnt_q) + AW'(1);
                end
            end
            ST_DRAIN: begin
                cnt_d = '0;
                if (abort) begin
                    state_d   = ST_IDLE;
                    w_valid_d = 1'b0;
                end else begin
                    state_d  = ST_DONE;
                    w_done_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    w_done_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            base_q   <= '0;
            mem_en   <= 1'b0;
            mem_addr <= '0;
            w_valid  <= 1'b0;
            w_row    <= '0;
            w_done   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            base_q   <= base_d;
            mem_en   <= mem_en_d;
            mem_addr <= mem_addr_d;
            w_valid  <= w_valid_d;
            w_row    <= w_row_d;
            w_done   <= w_done_d;
        end
    end

endmodule

// File: doc/weight_fetch.md
# weight_fetch

Weight-fetch stage that sits directly downstream of the accelerator controller. It serves the controller's W_FETCH phase. While `w_read` is high it streams SYS_H weight rows from the weight buffer, one row per cycle, into the systolic-array weight-load port. It then raises `w_done` so the controller can advance to BUSY. It also honours the controller's `clr` pulse as a synchronous abort/return-to-idle.

## Interface
Parameters:
- SYS_H, 8, systolic array rows = weight rows fetched per request
- SYS_W, 8, systolic array columns = weights per row
- DW, 8, bits per weight
- AW, 10, weight buffer address width

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- w_read  in  1  fetch request level from controller
- clr  in  1  synchronous clear from controller; priority over w_read
- base_addr  in  AW  first weight-row address; sampled on request acceptance
- mem_en  out  1  weight buffer read enable
- mem_addr  out  AW  weight buffer read address
- mem_rdata  in  SYS_W*DW  buffer read data, valid exactly 1 cycle after mem_en
- w_data  out  SYS_W*DW  row to array; equals mem_rdata (combinational pass-through)
- w_valid  out  1  w_data holds a valid row
- w_row  out  $clog2(SYS_H)  row index of w_data
- w_done  out  1  all SYS_H rows delivered; held until released

## Operation
- States:
  - IDLE: accept a request when w_read=1 and clr=0. Latch base_addr, set cnt=0, go to ISSUE.
  - ISSUE: mem_en=1, mem_addr=base+cnt, cnt++. After issuing cnt=SYS_H-1, go to DRAIN.
  - DRAIN: single cycle in which the last row's data is valid; then go to DONE.
  - DONE: w_done=1. Leave to IDLE when clr=1 or w_read=0.
- clr=1 in any state: next state IDLE, cnt=0, mem_en=0, and the in-flight w_valid is suppressed. The same-cycle w_read is ignored. This is required because the controller raises w_read and clr together on its start cycle.
- w_read falling in ISSUE or DRAIN: abort to IDLE, with the same clean-up as clr. No w_done.
- Address arithmetic: mem_addr = (base + cnt) mod 2^AW; it wraps silently at the top of the buffer.
- w_valid is mem_en delayed one cycle. w_row is cnt-at-issue delayed one cycle.
- Reset values: state IDLE, cnt 0, mem_en 0, mem_addr 0, w_valid 0, w_row 0, w_done 0.
- Reset asserted mid-fetch: all outputs go to their reset values immediately, with no w_done.

## Timing
- Request is sampled at the edge ending cycle t.
- mem_en is high for cycles t+1 … t+SYS_H, with addresses base … base+SYS_H-1.
- w_valid is high for cycles t+2 … t+SYS_H+1, with w_row 0 … SYS_H-1 in order and no gaps.
- w_done rises at cycle t+SYS_H+2, i.e. a latency of SYS_H+2 from request to done.
- w_done stays high until the edge after clr=1 or w_read=0 is sampled.
- A new request is accepted no earlier than the cycle after the block returns to IDLE.
- All outputs are registered except w_data.

## Structure
- Shared accelerator package holds:
  - the state enum (IDLE/ISSUE/DRAIN/DONE);
  - default SYS_H, SYS_W, DW, AW constants, shared with the controller and array.
- Single module. No sub-module; the counter and the 1-deep valid/row pipeline are inline.

## Test plan
- **Basic fetch:** SYS_H=8, base_addr=0x010, w_read held high after one cycle of w_read=1 with clr=1 → mem_addr 0x010…0x017 on cycles t+1…t+8; w_valid on t+2…t+9 with w_row 0…7; w_done at t+10.
- **Release:** at cycle t+11 hold w_done high, then assert clr=1 with w_read=0 → w_done stays high through t+11, is 0 at t+12, and the block returns to IDLE.
- **Wrap:** base_addr=0x3FC, AW=10 → addresses 0x3FC, 0x3FD, 0x3FE, 0x3FF, 0x000, 0x001, 0x002, 0x003.
- **Abort:** clr=1 at ISSUE cycle 3 → mem_en=0 from the next cycle; no w_valid after the aborted read; w_done never rises.
- **Start/clr collision:** w_read=1 and clr=1 together in IDLE → no mem_en; the fetch starts only on the following cycle with w_read=1 and clr=0.
- **Reset:** assert rst low mid-ISSUE, asynchronously and mid-cycle → mem_en, w_valid and w_done are 0 immediately; after release, a fresh request yields a full 8-row fetch.
